// File: rtl/ap_pkg.sv
// Shared encodings and 320-bit state slicing helpers for the Ascon-128 mode sequencer.
package ap_pkg;

  typedef enum logic [1:0] {
    CMD_INIT   = 2'b00,
    CMD_ABSORB = 2'b01,
    CMD_FINAL  = 2'b10,
    CMD_RSVD   = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PERM = 3'd1,
    ST_WAIT = 3'd2,
    ST_POST = 3'd3,
    ST_EMIT = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    POST_NONE  = 2'd0,
    POST_INIT  = 2'd1,
    POST_FINAL = 2'd2
  } post_e;

  localparam logic [63:0] AP_IV       = 64'h80400c0600000000;
  localparam int unsigned AP_ROUNDS_A = 12;
  localparam int unsigned AP_ROUNDS_B = 6;

  // State word i (0..4) occupies bits [319-64*i -: 64]; x0 is the rate word.
  function automatic logic [63:0] get_x(input logic [319:0] s, input int unsigned i);
    return s[319-64*i -: 64];
  endfunction

  function automatic logic [319:0] xor_x(input logic [319:0] s, input int unsigned i,
                                         input logic [63:0] v);
    logic [319:0] r;
    r = s;
    r[319-64*i -: 64] = r[319-64*i -: 64] ^ v;
    return r;
  endfunction

endpackage

// File: rtl/ap_mode_ctrl.sv
// Ascon-128 encryption sequencer: owns the permutation state and drives ap_core
// through init, data-block and finalization permutation calls.
module ap_mode_ctrl
  import ap_pkg::*;
#(
  parameter int unsigned CYC_PER_ROUND = 1,
  parameter int unsigned CORE_PIPE     = 1,
  parameter int unsigned ROUNDS_A      = AP_ROUNDS_A,
  parameter int unsigned ROUNDS_B      = AP_ROUNDS_B,
  parameter logic [63:0] IV            = AP_IV
) (
  input  logic         iClk,
  input  logic         iReset_n,
  input  logic         iCmd_valid,
  output logic         oCmd_ready,
  input  logic [1:0]   iCmd,
  input  logic [127:0] iKey,
  input  logic [127:0] iNonce,
  input  logic [63:0]  iData,
  input  logic         iLast,
  output logic [63:0]  oData,
  output logic         oData_valid,
  output logic [127:0] oTag,
  output logic         oTag_valid,
  output logic         oErr,
  output logic         oBusy,
  output logic         oCore_start,
  output logic [3:0]   oCore_rounds,
  output logic [319:0] oCore_state,
  input  logic [319:0] iCore_state
);

  localparam int unsigned CNT_MAX = 15 * CYC_PER_ROUND + CORE_PIPE;
  localparam int unsigned CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

  state_e             state;
  post_e              post;
  logic [319:0]       s;
  logic [127:0]       key;
  logic               inited;
  logic               done;
  logic [3:0]         rounds;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_load;
  logic               accept;
  logic               cmd_ok;

  assign oCmd_ready   = (state == ST_IDLE);
  assign oBusy        = ~oCmd_ready;
  assign oCore_start  = (state == ST_PERM);
  assign oCore_rounds = rounds;
  assign oCore_state  = s;
  assign accept       = iCmd_valid & oCmd_ready;

  always_comb begin
    cnt_load = CNT_W'(32'(rounds) * CYC_PER_ROUND + CORE_PIPE - 1);
  end

  always_comb begin
    cmd_ok = 1'b0;
    case (cmd_e'(iCmd))
      CMD_INIT:   cmd_ok = 1'b1;
      CMD_ABSORB: cmd_ok = inited & ~done;
      CMD_FINAL:  cmd_ok = done;
      default:    cmd_ok = 1'b0;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      state       <= ST_IDLE;
      post        <= POST_NONE;
      s           <= '0;
      key         <= '0;
      inited      <= 1'b0;
      done        <= 1'b0;
      rounds      <= '0;
      cnt         <= '0;
      oData       <= '0;
      oData_valid <= 1'b0;
      oTag        <= '0;
      oTag_valid  <= 1'b0;
      oErr        <= 1'b0;
    end else begin
      oData_valid <= 1'b0;
      oTag_valid  <= 1'b0;
      oErr        <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (!cmd_ok) begin
              oErr <= 1'b1;
            end else begin
              case (cmd_e'(iCmd))
                CMD_INIT: begin
                  s      <= {IV, iKey, iNonce};
                  key    <= iKey;
                  inited <= 1'b0;
                  done   <= 1'b0;
                  oTag   <= '0;
                  rounds <= 4'(ROUNDS_A);
                  post   <= POST_INIT;
                  state  <= ST_PERM;
                end
                CMD_ABSORB: begin
                  s           <= xor_x(s, 0, iData);
                  oData       <= get_x(s, 0) ^ iData;
                  oData_valid <= 1'b1;
                  if (iLast) begin
                    done  <= 1'b1;
                    state <= ST_EMIT;
                  end else begin
                    rounds <= 4'(ROUNDS_B);
                    post   <= POST_NONE;
                    state  <= ST_PERM;
                  end
                end
                CMD_FINAL: begin
                  s      <= xor_x(xor_x(s, 1, key[127:64]), 2, key[63:0]);
                  rounds <= 4'(ROUNDS_A);
                  post   <= POST_FINAL;
                  state  <= ST_PERM;
                end
                default: ;
              endcase
            end
          end
        end
        ST_PERM: begin
          cnt   <= cnt_load;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (cnt == '0) begin
            s     <= iCore_state;
            state <= (post == POST_NONE) ? ST_IDLE : ST_POST;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_POST: begin
          if (post == POST_INIT) begin
            // Key goes into the capacity tail (x3,x4), then the domain bit into x4[0].
            s      <= s ^ {192'd0, key} ^ 320'd1;
            inited <= 1'b1;
            done   <= 1'b0;
          end else begin
            oTag       <= {get_x(s, 3) ^ key[127:64], get_x(s, 4) ^ key[63:0]};
            oTag_valid <= 1'b1;
            inited     <= 1'b0;
            done       <= 1'b0;
          end
          post  <= POST_NONE;
          state <= ST_IDLE;
        end
        ST_EMIT: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ap_mode_ctrl.sv
// Scoreboard bench for ap_mode_ctrl with a behavioural Ascon permutation standing in for ap_core.
module tb_ap_mode_ctrl;
  import ap_pkg::*;

  localparam int unsigned CPR  = 1;
  localparam int unsigned PIPE = 1;
  localparam logic [127:0] KAT_KEY = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] KAT_TAG = 128'hE355159F292911F794CB1432A0103A8A;

  logic         clk = 1'b0;
  logic         iReset_n;
  logic         iCmd_valid;
  logic         oCmd_ready;
  logic [1:0]   iCmd;
  logic [127:0] iKey;
  logic [127:0] iNonce;
  logic [63:0]  iData;
  logic         iLast;
  logic [63:0]  oData;
  logic         oData_valid;
  logic [127:0] oTag;
  logic         oTag_valid;
  logic         oErr;
  logic         oBusy;
  logic         oCore_start;
  logic [3:0]   oCore_rounds;
  logic [319:0] oCore_state;
  logic [319:0] iCore_state;

  always #5 clk = ~clk;

  ap_mode_ctrl #(.CYC_PER_ROUND(CPR), .CORE_PIPE(PIPE)) dut (
    .iClk(clk), .iReset_n(iReset_n), .iCmd_valid(iCmd_valid), .oCmd_ready(oCmd_ready),
    .iCmd(iCmd), .iKey(iKey), .iNonce(iNonce), .iData(iData), .iLast(iLast),
    .oData(oData), .oData_valid(oData_valid), .oTag(oTag), .oTag_valid(oTag_valid),
    .oErr(oErr), .oBusy(oBusy), .oCore_start(oCore_start), .oCore_rounds(oCore_rounds),
    .oCore_state(oCore_state), .iCore_state(iCore_state)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic chk(input string tag, input logic [319:0] got, input logic [319:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ror(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [319:0] perm(input logic [319:0] st, input int unsigned nr);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    {x0, x1, x2, x3, x4} = st;
    for (int unsigned i = 12 - nr; i < 12; i++) begin
      x2 = x2 ^ {56'd0, 4'(15 - i), 4'(i)};
      x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
      t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
      x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
      x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
      x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
      x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
      x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
      x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
      x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
    end
    return {x0, x1, x2, x3, x4};
  endfunction

  // ap_core stand-in: junk on the bus until the result is due, so an early latch shows up.
  logic [319:0] core_res;
  int           core_rem;
  bit           core_act = 1'b0;
  always @(posedge clk) begin
    if (!iReset_n) begin
      core_act = 1'b0;
    end else if (oCore_start) begin
      core_res = perm(oCore_state, int'(oCore_rounds));
      core_rem = int'(oCore_rounds) * CPR + PIPE - 1;
      core_act = 1'b1;
      #1 iCore_state = {10{$urandom()}};
      if (core_rem == 0) begin
        iCore_state = core_res;
        core_act    = 1'b0;
      end
    end else if (core_act) begin
      core_rem--;
      if (core_rem == 0) begin
        #1 iCore_state = core_res;
        core_act = 1'b0;
      end
    end
  end

  logic [63:0]  exp_data_q[$];
  logic [127:0] exp_tag_q[$];
  int           exp_rnd_q[$];
  int           exp_err_q[$];

  always @(negedge clk) begin
    if (oData_valid === 1'b1) begin
      if (exp_data_q.size() == 0) chk("data_unexpected", 1, 0);
      else chk("data", oData, exp_data_q.pop_front());
    end
    if (oTag_valid === 1'b1) begin
      if (exp_tag_q.size() == 0) chk("tag_unexpected", 1, 0);
      else chk("tag", oTag, exp_tag_q.pop_front());
    end
    if (oErr === 1'b1) begin
      if (exp_err_q.size() == 0) chk("err_unexpected", 1, 0);
      else void'(exp_err_q.pop_front());
    end
    if (oCore_start === 1'b1) begin
      if (exp_rnd_q.size() == 0) chk("start_unexpected", 1, 0);
      else chk("rounds", oCore_rounds, exp_rnd_q.pop_front());
    end
  end

  logic [319:0] s_m;
  logic [127:0] key_m, key_in, nonce_in, last_tag_m;
  bit           ini_m, done_m;

  task automatic do_reset(input int unsigned cyc);
    iReset_n = 1'b0;
    repeat (cyc) @(posedge clk);
    #1 iReset_n = 1'b1;
    s_m = '0; key_m = '0; ini_m = 1'b0; done_m = 1'b0;
  endtask

  task automatic do_cmd(input logic [1:0] cmd, input logic [63:0] data, input logic last,
                        input bit wait_done);
    bit          legal, acc;
    int unsigned exp_lat, n;
    legal = (cmd == 2'b00) || (cmd == 2'b01 && ini_m && !done_m) || (cmd == 2'b10 && done_m);
    exp_lat = 0;
    if (!legal) begin
      exp_err_q.push_back(1);
    end else if (cmd == 2'b00) begin
      s_m = perm({AP_IV, key_in, nonce_in}, 12);
      s_m[127:0] = s_m[127:0] ^ key_in;
      s_m[0] = ~s_m[0];
      key_m = key_in; ini_m = 1'b1; done_m = 1'b0;
      exp_rnd_q.push_back(12);
      exp_lat = 2 + 12 * CPR + PIPE;
    end else if (cmd == 2'b01) begin
      s_m[319:256] = s_m[319:256] ^ data;
      exp_data_q.push_back(s_m[319:256]);
      if (last) begin
        done_m = 1'b1;
        exp_lat = 1;
      end else begin
        s_m = perm(s_m, 6);
        exp_rnd_q.push_back(6);
        exp_lat = 1 + 6 * CPR + PIPE;
      end
    end else begin
      s_m[255:192] = s_m[255:192] ^ key_m[127:64];
      s_m[191:128] = s_m[191:128] ^ key_m[63:0];
      s_m = perm(s_m, 12);
      last_tag_m = {s_m[127:64] ^ key_m[127:64], s_m[63:0] ^ key_m[63:0]};
      exp_tag_q.push_back(last_tag_m);
      exp_rnd_q.push_back(12);
      ini_m = 1'b0; done_m = 1'b0;
      exp_lat = 2 + 12 * CPR + PIPE;
    end
    iCmd_valid = 1'b1; iCmd = cmd; iData = data; iLast = last;
    iKey = key_in; iNonce = nonce_in;
    n = 0;
    do begin
      acc = oCmd_ready;
      @(posedge clk);
      #1 n++;
    end while (!acc && n < 200);
    if (!acc) chk("accept_timeout", 0, 1);
    iCmd_valid = 1'b0; iCmd = 2'($urandom()); iData = {$urandom(), $urandom()};
    iLast = 1'($urandom()); iKey = ~key_in; iNonce = ~nonce_in;
    if (wait_done) begin
      n = 0;
      while (!oCmd_ready && n < 200) begin
        @(posedge clk);
        #1 n++;
      end
      chk("latency", n, exp_lat);
      chk("state", oCore_state, s_m);
    end
  endtask

  initial begin
    iCmd_valid = 1'b0; iCmd = '0; iKey = '0; iNonce = '0; iData = '0; iLast = 1'b0;
    iCore_state = '0;
    key_in = KAT_KEY; nonce_in = KAT_KEY;
    do_reset(2);
    chk("rst_ready", oCmd_ready, 1);
    chk("rst_busy", oBusy, 0);
    chk("rst_start", oCore_start, 0);
    chk("rst_tag", oTag, 0);
    chk("rst_err", oErr, 0);
    chk("rst_tag_valid", oTag_valid, 0);
    chk("rst_state", oCore_state, 0);

    // Illegal commands straight out of reset, then the empty-message KAT.
    do_cmd(2'b01, 64'h1234, 1'b0, 1'b1);
    do_cmd(2'b11, 64'h0, 1'b0, 1'b1);
    do_cmd(2'b00, 64'h0, 1'b0, 1'b1);
    do_cmd(2'b10, 64'h0, 1'b0, 1'b1);
    do_cmd(2'b01, 64'h8000000000000000, 1'b1, 1'b1);
    do_cmd(2'b10, 64'h0, 1'b0, 1'b1);
    chk("kat_tag", oTag, KAT_TAG);
    do_cmd(2'b01, 64'h55, 1'b1, 1'b1);

    // Three-block message; the second ABSORB is presented while the first is still permuting.
    key_in = {$urandom(), $urandom(), $urandom(), $urandom()};
    nonce_in = {$urandom(), $urandom(), $urandom(), $urandom()};
    do_cmd(2'b00, 64'h0, 1'b0, 1'b1);
    do_cmd(2'b01, {$urandom(), $urandom()}, 1'b0, 1'b0);
    do_cmd(2'b01, {$urandom(), $urandom()}, 1'b0, 1'b1);
    do_cmd(2'b01, {$urandom(), 32'h80000000}, 1'b1, 1'b1);
    do_cmd(2'b01, 64'hdead, 1'b1, 1'b1);
    do_cmd(2'b10, 64'h0, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1 chk("tag_hold", oTag, last_tag_m);

    // INIT restarts mid-message and clears the flags, so FINAL is then illegal.
    do_cmd(2'b00, 64'h0, 1'b0, 1'b1);
    do_cmd(2'b01, {$urandom(), $urandom()}, 1'b0, 1'b1);
    do_cmd(2'b00, 64'h0, 1'b0, 1'b1);
    do_cmd(2'b10, 64'h0, 1'b0, 1'b1);

    // Reset during WAIT, then a clean run.
    do_cmd(2'b00, 64'h0, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1 do_reset(1);
    chk("midrst_ready", oCmd_ready, 1);
    chk("midrst_state", oCore_state, 0);
    chk("midrst_tag", oTag, 0);
    repeat (20) @(posedge clk);
    #1 chk("midrst_idle", oCmd_ready, 1);
    do_cmd(2'b00, 64'h0, 1'b0, 1'b1);
    do_cmd(2'b01, {$urandom(), 32'h00800000}, 1'b1, 1'b1);
    do_cmd(2'b10, 64'h0, 1'b0, 1'b1);

    repeat (5) @(posedge clk);
    #1;
    chk("data_q_drained", exp_data_q.size(), 0);
    chk("tag_q_drained", exp_tag_q.size(), 0);
    chk("err_q_drained", exp_err_q.size(), 0);
    chk("start_q_drained", exp_rnd_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
